// File: rtl/ctrlport_req_initiator_if.sv
// Command, ctrlport request/response and response stream bundle
// for the single-outstanding ctrlport initiator.
interface ctrlport_req_initiator_if;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic        s_cmd_wr;
    logic [19:0] s_cmd_addr;
    logic [31:0] s_cmd_data;
    logic [3:0]  s_cmd_byte_en;

    logic        m_ctrlport_req_wr;
    logic        m_ctrlport_req_rd;
    logic [19:0] m_ctrlport_req_addr;
    logic [31:0] m_ctrlport_req_data;
    logic [3:0]  m_ctrlport_req_byte_en;
    logic        m_ctrlport_resp_ack;
    logic [1:0]  m_ctrlport_resp_status;
    logic [31:0] m_ctrlport_resp_data;

    logic        m_rsp_valid;
    logic        m_rsp_ready;
    logic [1:0]  m_rsp_status;
    logic [31:0] m_rsp_data;
    logic        m_rsp_timeout;

    modport master (
        input  s_cmd_valid, s_cmd_wr, s_cmd_addr,
        input  s_cmd_data, s_cmd_byte_en,
        output s_cmd_ready,
        output m_ctrlport_req_wr, m_ctrlport_req_rd,
        output m_ctrlport_req_addr, m_ctrlport_req_data,
        output m_ctrlport_req_byte_en,
        input  m_ctrlport_resp_ack, m_ctrlport_resp_status,
        input  m_ctrlport_resp_data,
        output m_rsp_valid, m_rsp_status, m_rsp_data,
        output m_rsp_timeout,
        input  m_rsp_ready
    );

    modport slave (
        output s_cmd_valid, s_cmd_wr, s_cmd_addr,
        output s_cmd_data, s_cmd_byte_en,
        input  s_cmd_ready,
        input  m_ctrlport_req_wr, m_ctrlport_req_rd,
        input  m_ctrlport_req_addr, m_ctrlport_req_data,
        input  m_ctrlport_req_byte_en,
        output m_ctrlport_resp_ack, m_ctrlport_resp_status,
        output m_ctrlport_resp_data,
        input  m_rsp_valid, m_rsp_status, m_rsp_data,
        input  m_rsp_timeout,
        output m_rsp_ready
    );
endinterface

// File: rtl/ctrlport_req_initiator.sv
// Single-outstanding ctrlport initiator: one request per command,
// waits for ack or timeout, returns status/data on a response stream.
module ctrlport_req_initiator #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                        ctrlport_clk,
    input  logic                        ctrlport_rst,
    ctrlport_req_initiator_if.master    bus,
    output logic                        busy,
    output logic [7:0]                  timeout_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // WAIT counter starts at 0 in the first WAIT cycle
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_take_ack;
    logic        w_timeout;
    logic [15:0] r_cnt;
    logic        r_req_wr;
    logic        r_req_rd;
    logic [19:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_be;
    logic        r_rsp_valid;
    logic [1:0]  r_rsp_status;
    logic [31:0] r_rsp_data;
    logic        r_rsp_timeout;
    logic        r_busy;
    logic [7:0]  r_to_count;

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_take_ack = 1'b0;
        w_timeout  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.s_cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = REQ;
                end
            end
            REQ: begin
                w_next = WAIT;
                if (bus.m_ctrlport_resp_ack) begin
                    w_take_ack = 1'b1;
                    w_next     = RESP;
                end
            end
            WAIT: begin
                if (bus.m_ctrlport_resp_ack) begin
                    w_take_ack = 1'b1;
                    w_next     = RESP;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP: begin
                if (bus.m_rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ctrlport_clk) begin
        if (!ctrlport_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_req_wr      <= 1'b0;
            r_req_rd      <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_be          <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_to_count    <= '0;
        end else begin
            r_state     <= w_next;
            r_req_wr    <= w_accept && bus.s_cmd_wr;
            r_req_rd    <= w_accept && !bus.s_cmd_wr;
            r_rsp_valid <= (w_next == RESP);
            r_busy      <= (w_next != IDLE);
            if (w_accept) begin
                r_addr <= bus.s_cmd_addr;
                r_data <= bus.s_cmd_data;
                r_be   <= bus.s_cmd_byte_en;
            end
            if (r_state == REQ)
                r_cnt <= '0;
            else if (r_state == WAIT)
                r_cnt <= r_cnt + 16'd1;
            if (w_take_ack) begin
                r_rsp_status  <= bus.m_ctrlport_resp_status;
                r_rsp_data    <= bus.m_ctrlport_resp_data;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_status  <= 2'b01;
                r_rsp_data    <= '0;
                r_rsp_timeout <= 1'b1;
                if (r_to_count != 8'hFF)
                    r_to_count <= r_to_count + 8'd1;
            end
        end
    end

    // Gated by reset so no command is taken while reset is held
    assign bus.s_cmd_ready = (r_state == IDLE) && ctrlport_rst;

    assign bus.m_ctrlport_req_wr      = r_req_wr;
    assign bus.m_ctrlport_req_rd      = r_req_rd;
    assign bus.m_ctrlport_req_addr    = r_addr;
    assign bus.m_ctrlport_req_data    = r_data;
    assign bus.m_ctrlport_req_byte_en = r_be;
    assign bus.m_rsp_valid            = r_rsp_valid;
    assign bus.m_rsp_status           = r_rsp_status;
    assign bus.m_rsp_data             = r_rsp_data;
    assign bus.m_rsp_timeout          = r_rsp_timeout;
    assign busy                       = r_busy;
    assign timeout_count              = r_to_count;
endmodule

// File: tb/tb_ctrlport_req_initiator.sv
// Directed bench for ctrlport_req_initiator with TIMEOUT_CYCLES = 8:
// ack latency, timeout, late ack, stall, throughput, saturation, reset.
module tb_ctrlport_req_initiator;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [7:0] tcount;
    logic       auto_ack;
    logic       man_ack;
    logic [1:0] ack_st;
    logic [31:0] ack_dat;
    int         checks = 0;
    int         errors = 0;
    int         n_wr = 0;
    int         n_rd = 0;
    int         n_both = 0;

    ctrlport_req_initiator_if bus ();

    ctrlport_req_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .ctrlport_clk  (clk),
        .ctrlport_rst  (rst_n),
        .bus           (bus),
        .busy          (busy),
        .timeout_count (tcount)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.m_ctrlport_resp_ack = auto_ack
            ? (bus.m_ctrlport_req_wr | bus.m_ctrlport_req_rd)
            : man_ack;
        bus.m_ctrlport_resp_status = ack_st;
        bus.m_ctrlport_resp_data   = ack_dat;
    end

    always @(posedge clk) begin
        if (bus.m_ctrlport_req_wr) n_wr++;
        if (bus.m_ctrlport_req_rd) n_rd++;
        if (bus.m_ctrlport_req_wr && bus.m_ctrlport_req_rd) n_both++;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns cycles from
    // the request-pulse cycle to the first m_rsp_valid cycle.
    task automatic do_txn(input logic wr, input logic [19:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input int dly, input logic [1:0] st,
                          input logic [31:0] ad, output int lat);
        bus.s_cmd_valid   = 1'b1;
        bus.s_cmd_wr      = wr;
        bus.s_cmd_addr    = addr;
        bus.s_cmd_data    = data;
        bus.s_cmd_byte_en = be;
        @(negedge clk);
        bus.s_cmd_valid = 1'b0;
        check("pulse_wr", bus.m_ctrlport_req_wr, wr);
        check("pulse_rd", bus.m_ctrlport_req_rd, !wr);
        check("pulse_addr", bus.m_ctrlport_req_addr, addr);
        check("pulse_data", bus.m_ctrlport_req_data, data);
        check("pulse_be", bus.m_ctrlport_req_byte_en, be);
        lat = -1;
        for (int j = 0; j < 100; j++) begin
            man_ack = 1'b0;
            if (bus.m_rsp_valid) begin
                lat = j;
                break;
            end
            if (j == dly) begin
                man_ack = 1'b1;
                ack_st  = st;
                ack_dat = ad;
            end
            @(negedge clk);
        end
        man_ack = 1'b0;
        if (lat < 0) check("rsp_timeout_bound", 0, 1);
    endtask

    task automatic take_rsp();
        bus.m_rsp_ready = 1'b1;
        @(negedge clk);
        bus.m_rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int w0;
        int r0;
        int cnt;
        int bad;
        logic [31:0] sd;
        rst_n             = 1'b0;
        auto_ack          = 1'b0;
        man_ack           = 1'b0;
        ack_st            = '0;
        ack_dat           = '0;
        bus.s_cmd_valid   = 1'b0;
        bus.s_cmd_wr      = 1'b0;
        bus.s_cmd_addr    = '0;
        bus.s_cmd_data    = '0;
        bus.s_cmd_byte_en = '0;
        bus.m_rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.s_cmd_ready, 0);
        check("rst_valid", bus.m_rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tcount", tcount, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", bus.s_cmd_ready, 1);
        check("post_rst_req_wr", bus.m_ctrlport_req_wr, 0);

        // write, ack 2 cycles after pulse
        w0 = n_wr; r0 = n_rd;
        do_txn(1'b1, 20'h01004, 32'hDEADBEEF, 4'hF, 2, 2'b00,
               32'hAAAA0000, lat);
        check("wr_lat", lat, 3);
        check("wr_status", bus.m_rsp_status, 0);
        check("wr_timeout", bus.m_rsp_timeout, 0);
        check("wr_data", bus.m_rsp_data, 32'hAAAA0000);
        check("wr_ready_low", bus.s_cmd_ready, 0);
        check("wr_busy", busy, 1);
        check("wr_npulse", n_wr - w0, 1);
        check("wr_nrd", n_rd - r0, 0);
        take_rsp();

        // read, ack in pulse cycle
        do_txn(1'b0, 20'h00C00, 32'h0, 4'hF, 0, 2'b00,
               32'h12345678, lat);
        check("rd_lat", lat, 1);
        check("rd_data", bus.m_rsp_data, 32'h12345678);
        check("rd_status", bus.m_rsp_status, 0);
        take_rsp();

        // timeout, then a late ack that must be ignored
        r0 = n_rd;
        do_txn(1'b0, 20'h00040, 32'h0, 4'h3, -1, 2'b00, 32'h0, lat);
        check("to_lat", lat, TO + 1);
        check("to_status", bus.m_rsp_status, 2'b01);
        check("to_data", bus.m_rsp_data, 0);
        check("to_flag", bus.m_rsp_timeout, 1);
        check("to_count1", tcount, 1);
        repeat (2) @(negedge clk);
        man_ack = 1'b1; ack_st = 2'b10; ack_dat = 32'h55555555;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        check("late_status", bus.m_rsp_status, 2'b01);
        check("late_data", bus.m_rsp_data, 0);
        check("late_flag", bus.m_rsp_timeout, 1);
        check("late_valid", bus.m_rsp_valid, 1);
        check("late_nrd", n_rd - r0, 1);
        take_rsp();

        // ack in the final timeout cycle wins
        do_txn(1'b0, 20'h00100, 32'h0, 4'hF, TO, 2'b11,
               32'hCAFEF00D, lat);
        check("edge_lat", lat, TO + 1);
        check("edge_data", bus.m_rsp_data, 32'hCAFEF00D);
        check("edge_status", bus.m_rsp_status, 2'b11);
        check("edge_flag", bus.m_rsp_timeout, 0);
        check("edge_tcount", tcount, 1);
        take_rsp();

        // response stalled for 20 cycles
        do_txn(1'b0, 20'h00200, 32'h0, 4'hF, 1, 2'b10,
               32'h0BADF00D, lat);
        check("stall_lat", lat, 2);
        bad = 0;
        sd  = bus.m_rsp_data;
        repeat (20) begin
            @(negedge clk);
            if (!bus.m_rsp_valid || bus.s_cmd_ready ||
                bus.m_rsp_data != sd || bus.m_rsp_status != 2'b10)
                bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_data", sd, 32'h0BADF00D);
        take_rsp();
        check("release_ready", bus.s_cmd_ready, 1);
        do_txn(1'b1, 20'h00300, 32'h11112222, 4'h1, 0, 2'b00,
               32'h0, lat);
        check("release_lat", lat, 1);
        take_rsp();

        // back-to-back writes, immediate ack, ready held high
        w0 = n_wr;
        auto_ack = 1'b1;
        ack_st = 2'b00;
        bus.m_rsp_ready = 1'b1;
        bus.s_cmd_valid = 1'b1;
        bus.s_cmd_wr = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.s_cmd_valid && bus.s_cmd_ready) cnt++;
            @(negedge clk);
        end
        bus.s_cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_accepts", cnt, 10);
        check("b2b_pulses", n_wr - w0, 10);

        // 300 forced timeouts saturate the counter
        auto_ack = 1'b0;
        bus.s_cmd_wr = 1'b0;
        bus.s_cmd_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6000 && cnt < 300; i++) begin
            if (bus.m_rsp_valid && bus.m_rsp_ready) cnt++;
            if (cnt == 300) bus.s_cmd_valid = 1'b0;
            @(negedge clk);
        end
        bus.s_cmd_valid = 1'b0;
        bus.m_rsp_ready = 1'b0;
        @(negedge clk);
        check("sat_resps", cnt, 300);
        check("sat_tcount", tcount, 255);

        // reset during WAIT abandons the command
        bus.s_cmd_valid = 1'b1;
        bus.s_cmd_wr = 1'b0;
        @(negedge clk);
        bus.s_cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", bus.m_rsp_valid, 0);
        check("mid_rst_ready", bus.s_cmd_ready, 0);
        check("mid_rst_tcount", tcount, 0);
        check("mid_rst_rd", bus.m_ctrlport_req_rd, 0);
        rst_n = 1'b1;
        r0 = n_rd;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.m_rsp_valid) bad++;
        end
        check("abandon_rsp", bad, 0);
        check("abandon_pulse", n_rd - r0, 0);
        check("abandon_ready", bus.s_cmd_ready, 1);
        check("both_pulses", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
